// File: rtl/cv32e40p_lce_responder.sv
// rtl/cv32e40p_lce_responder.sv - loop-lockup alarm responder: debounce, kill req/ack, hold-off, status
// Filters the detector alarm, raises a held kill request, and keeps sticky/count status for software.

module cv32e40p_lce_responder #(
  parameter int unsigned ALARM_FILTER   = 2,
  parameter int unsigned HOLDOFF_CYCLES = 16,
  parameter int unsigned CNT_WIDTH      = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 alarm_i,
  input  logic                 enable_i,
  output logic                 kill_req_o,
  input  logic                 kill_ack_i,
  input  logic                 clear_i,
  output logic                 sticky_o,
  output logic [CNT_WIDTH-1:0] event_cnt_o,
  output logic                 busy_o
);

  localparam int unsigned FILT_W     = $clog2(ALARM_FILTER + 1);
  localparam int unsigned HOLD_W_RAW = $clog2(HOLDOFF_CYCLES + 1);
  localparam int unsigned HOLD_W     = (HOLD_W_RAW < 1) ? 1 : HOLD_W_RAW;

  localparam logic [FILT_W-1:0]    FILT_LAST = FILT_W'(ALARM_FILTER);
  localparam logic [HOLD_W-1:0]    HOLD_LOAD = HOLD_W'(HOLDOFF_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILTER  = 2'd1,
    REQ     = 2'd2,
    HOLDOFF = 2'd3
  } state_e;

  state_e                state_q;
  state_e                state_n;
  logic [FILT_W-1:0]     filt_cnt_q;
  logic [FILT_W-1:0]     filt_cnt_n;
  logic [FILT_W-1:0]     filt_inc;
  logic [HOLD_W-1:0]     hold_cnt_q;
  logic [HOLD_W-1:0]     hold_cnt_n;
  logic                  alarm_en;
  logic                  ack_evt;
  logic [CNT_WIDTH-1:0]  cnt_base;
  logic [CNT_WIDTH-1:0]  cnt_n;
  logic                  sticky_n;

  assign alarm_en = alarm_i && enable_i;
  assign filt_inc = filt_cnt_q + FILT_W'(1);

  always_comb begin
    state_n    = state_q;
    filt_cnt_n = filt_cnt_q;
    hold_cnt_n = hold_cnt_q;
    ack_evt    = 1'b0;

    case (state_q)
      IDLE: begin
        if (alarm_en) begin
          if (ALARM_FILTER == 1) begin
            state_n    = REQ;
            filt_cnt_n = '0;
          end else begin
            state_n    = FILTER;
            filt_cnt_n = FILT_W'(1);
          end
        end
      end

      FILTER: begin
        // Any gap in the enabled alarm restarts the debounce from scratch.
        if (alarm_en) begin
          if (filt_inc == FILT_LAST) begin
            state_n    = REQ;
            filt_cnt_n = '0;
          end else begin
            filt_cnt_n = filt_inc;
          end
        end else begin
          state_n    = IDLE;
          filt_cnt_n = '0;
        end
      end

      REQ: begin
        // Once raised, the request stays up until the controller takes it.
        if (kill_ack_i) begin
          ack_evt = 1'b1;
          if (HOLDOFF_CYCLES > 0) begin
            state_n    = HOLDOFF;
            hold_cnt_n = HOLD_LOAD;
          end else begin
            state_n = IDLE;
          end
        end
      end

      HOLDOFF: begin
        if (hold_cnt_q == HOLD_W'(1)) begin
          state_n    = IDLE;
          hold_cnt_n = '0;
        end else begin
          hold_cnt_n = hold_cnt_q - HOLD_W'(1);
        end
      end

      default: begin
        state_n    = IDLE;
        filt_cnt_n = '0;
        hold_cnt_n = '0;
      end
    endcase
  end

  // Clear is applied before the increment so a coincident ack is still counted.
  always_comb begin
    cnt_base = clear_i ? '0 : event_cnt_o;
    cnt_n    = cnt_base;
    if (ack_evt && (cnt_base != CNT_MAX)) begin
      cnt_n = cnt_base + CNT_WIDTH'(1);
    end
    sticky_n = ack_evt || (sticky_o && !clear_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      filt_cnt_q  <= '0;
      hold_cnt_q  <= '0;
      kill_req_o  <= 1'b0;
      busy_o      <= 1'b0;
      sticky_o    <= 1'b0;
      event_cnt_o <= '0;
    end else begin
      state_q     <= state_n;
      filt_cnt_q  <= filt_cnt_n;
      hold_cnt_q  <= hold_cnt_n;
      kill_req_o  <= (state_n == REQ);
      busy_o      <= (state_n != IDLE);
      sticky_o    <= sticky_n;
      event_cnt_o <= cnt_n;
    end
  end

endmodule

// File: tb/tb_cv32e40p_lce_responder.sv
// tb/tb_cv32e40p_lce_responder.sv - scoreboard bench for cv32e40p_lce_responder
// u0: filter 2, hold-off 16, 8-bit count; u1: filter 1, no hold-off, 2-bit count.

module tb_cv32e40p_lce_responder;

  logic       clk = 1'b0;
  logic       rst_n0, alarm0, en0, ack0, clr0, kill0, sticky0, busy0;
  logic [7:0] cnt0;
  logic       rst_n1, alarm1, en1, ack1, clr1, kill1, sticky1, busy1;
  logic [1:0] cnt1;

  int tests = 0;
  int fails = 0;

  // bench-side status model
  int mc0 = 0, mc1 = 0;
  logic ms0 = 1'b0, ms1 = 1'b0;

  typedef struct {
    string      tag;
    int         inst;
    logic       kill;
    logic       busy;
    logic       sticky;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  cv32e40p_lce_responder #(.ALARM_FILTER(2), .HOLDOFF_CYCLES(16), .CNT_WIDTH(8)) u0 (
    .clk(clk), .rst_n(rst_n0), .alarm_i(alarm0), .enable_i(en0), .kill_req_o(kill0),
    .kill_ack_i(ack0), .clear_i(clr0), .sticky_o(sticky0), .event_cnt_o(cnt0), .busy_o(busy0)
  );

  cv32e40p_lce_responder #(.ALARM_FILTER(1), .HOLDOFF_CYCLES(0), .CNT_WIDTH(2)) u1 (
    .clk(clk), .rst_n(rst_n1), .alarm_i(alarm1), .enable_i(en1), .kill_req_o(kill1),
    .kill_ack_i(ack1), .clear_i(clr1), .sticky_o(sticky1), .event_cnt_o(cnt1), .busy_o(busy1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string tag, input string fld, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s %s: observed %0d expected %0d", tag, fld, obs, exp);
    end
  endtask

  task automatic expect_state(input string tag, input int inst, input logic k, input logic b);
    exp_t e;
    e.tag    = tag;
    e.inst   = inst;
    e.kill   = k;
    e.busy   = b;
    e.sticky = (inst == 0) ? ms0 : ms1;
    e.cnt    = (inst == 0) ? mc0 : mc1;
    sb.push_back(e);
  endtask

  task automatic check_next();
    exp_t e;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL scoreboard: observed empty queue expected an entry");
    end else begin
      e = sb.pop_front();
      if (e.inst == 0) begin
        cmp(e.tag, "kill", {31'b0, kill0}, {31'b0, e.kill});
        cmp(e.tag, "busy", {31'b0, busy0}, {31'b0, e.busy});
        cmp(e.tag, "sticky", {31'b0, sticky0}, {31'b0, e.sticky});
        cmp(e.tag, "cnt", {24'b0, cnt0}, e.cnt);
      end else begin
        cmp(e.tag, "kill", {31'b0, kill1}, {31'b0, e.kill});
        cmp(e.tag, "busy", {31'b0, busy1}, {31'b0, e.busy});
        cmp(e.tag, "sticky", {31'b0, sticky1}, {31'b0, e.sticky});
        cmp(e.tag, "cnt", {30'b0, cnt1}, e.cnt);
      end
    end
  endtask

  function automatic int sat_inc(input int v, input int maxv);
    return (v >= maxv) ? maxv : v + 1;
  endfunction

  // Full kill sequence; hold_cycles spends extra REQ cycles with alarm/enable dropped.
  task automatic run_kill(input string tag, input int inst, input bit clr_at_ack, input int hold_cycles);
    if (inst == 0) begin
      alarm0 = 1'b1; en0 = 1'b1;
      expect_state({tag, ".filt"}, 0, 1'b0, 1'b1);
      step(); check_next();
    end else begin
      alarm1 = 1'b1; en1 = 1'b1;
    end
    expect_state({tag, ".req"}, inst, 1'b1, 1'b1);
    step(); check_next();
    if (inst == 0) begin alarm0 = 1'b0; en0 = 1'b0; end else begin alarm1 = 1'b0; en1 = 1'b0; end
    for (int i = 0; i < hold_cycles; i++) begin
      expect_state({tag, ".hold"}, inst, 1'b1, 1'b1);
      step(); check_next();
    end
    if (inst == 0) begin
      en0 = 1'b1; ack0 = 1'b1; clr0 = clr_at_ack;
      if (clr_at_ack) mc0 = 0;
      mc0 = sat_inc(mc0, 255); ms0 = 1'b1;
      expect_state({tag, ".ack"}, 0, 1'b0, 1'b1);
      step(); check_next();
      ack0 = 1'b0; clr0 = 1'b0;
      for (int i = 0; i < 15; i++) begin
        expect_state({tag, ".holdoff"}, 0, 1'b0, 1'b1);
        step(); check_next();
      end
      expect_state({tag, ".idle"}, 0, 1'b0, 1'b0);
      step(); check_next();
    end else begin
      en1 = 1'b1; ack1 = 1'b1; clr1 = clr_at_ack;
      if (clr_at_ack) mc1 = 0;
      mc1 = sat_inc(mc1, 3); ms1 = 1'b1;
      expect_state({tag, ".ack"}, 1, 1'b0, 1'b0);
      step(); check_next();
      ack1 = 1'b0; clr1 = 1'b0;
    end
  endtask

  initial begin
    rst_n0 = 1'b0; alarm0 = 1'b0; en0 = 1'b1; ack0 = 1'b0; clr0 = 1'b0;
    rst_n1 = 1'b0; alarm1 = 1'b0; en1 = 1'b1; ack1 = 1'b0; clr1 = 1'b0;
    step(); step();
    expect_state("reset0", 0, 1'b0, 1'b0); check_next();
    expect_state("reset1", 1, 1'b0, 1'b0); check_next();
    rst_n0 = 1'b1; rst_n1 = 1'b1;
    step();

    // basic kill: request two edges after alarm, held until ack, 16-cycle hold-off
    run_kill("t1", 0, 1'b0, 2);

    // single-cycle glitch does not reach REQ
    alarm0 = 1'b1;
    expect_state("t2.glitch_hi", 0, 1'b0, 1'b1);
    step(); check_next();
    alarm0 = 1'b0;
    expect_state("t2.glitch_lo", 0, 1'b0, 1'b0);
    step(); check_next();
    // disabled response ignores a long alarm
    en0 = 1'b0; alarm0 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      expect_state("t2.disabled", 0, 1'b0, 1'b0);
      step(); check_next();
    end
    alarm0 = 1'b0; en0 = 1'b1;
    // ack outside REQ is ignored
    ack0 = 1'b1;
    expect_state("t2.stray_ack", 0, 1'b0, 1'b0);
    step(); check_next();
    ack0 = 1'b0;

    // persistent alarm re-requests two cycles after hold-off ends
    alarm0 = 1'b1;
    expect_state("t3.filt", 0, 1'b0, 1'b1);
    step(); check_next();
    expect_state("t3.req", 0, 1'b1, 1'b1);
    step(); check_next();
    ack0 = 1'b1; mc0 = sat_inc(mc0, 255); ms0 = 1'b1;
    expect_state("t3.ack", 0, 1'b0, 1'b1);
    step(); check_next();
    ack0 = 1'b0;
    repeat (15) step();
    expect_state("t3.idle", 0, 1'b0, 1'b0);
    step(); check_next();
    expect_state("t3.refilt", 0, 1'b0, 1'b1);
    step(); check_next();
    expect_state("t3.rereq", 0, 1'b1, 1'b1);
    step(); check_next();
    alarm0 = 1'b0; ack0 = 1'b1; mc0 = sat_inc(mc0, 255);
    expect_state("t3.ack2", 0, 1'b0, 1'b1);
    step(); check_next();
    ack0 = 1'b0;
    repeat (15) step();
    expect_state("t3.idle2", 0, 1'b0, 1'b0);
    step(); check_next();

    // request held 50 cycles with alarm/enable dropped
    run_kill("t4", 0, 1'b0, 50);

    // reach 5, then clear coincident with ack
    run_kill("t5.pre", 0, 1'b0, 0);
    run_kill("t5.clr_ack", 0, 1'b1, 0);
    // clear alone while in REQ: status zeroed, request untouched
    alarm0 = 1'b1;
    expect_state("t5.filt", 0, 1'b0, 1'b1);
    step(); check_next();
    expect_state("t5.req", 0, 1'b1, 1'b1);
    step(); check_next();
    alarm0 = 1'b0; clr0 = 1'b1; mc0 = 0; ms0 = 1'b0;
    expect_state("t5.clr_only", 0, 1'b1, 1'b1);
    step(); check_next();
    clr0 = 1'b0; ack0 = 1'b1; mc0 = sat_inc(mc0, 255); ms0 = 1'b1;
    expect_state("t5.ack", 0, 1'b0, 1'b1);
    step(); check_next();
    ack0 = 1'b0;

    // 2-bit counter saturates at 3
    for (int i = 0; i < 5; i++) run_kill("t6.kill", 1, 1'b0, 0);
    // async reset mid-REQ
    alarm1 = 1'b1;
    expect_state("t6.req", 1, 1'b1, 1'b1);
    step(); check_next();
    #3 rst_n1 = 1'b0;
    mc1 = 0; ms1 = 1'b0;
    #1;
    expect_state("t6.async_rst", 1, 1'b0, 1'b0);
    check_next();
    alarm1 = 1'b0;
    step();
    rst_n1 = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
